dm_access_ctrl: RTL and testbench

//  Data-memory access controller directly upstream of the bus-connect mux: produces dm_bc_dt.

---
 rtl/dm_ctrl_pkg.sv | 21 ++
 rtl/dm_wait_cnt.sv | 37 +++
 rtl/dm_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dm_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   ST_IDLE / ST_ACCESS  controller state encoding
//   WAIT_CW              wait-state counter width (holds 0..15)
//   OP_RD / OP_WR        latched operation type
//   wait_cnt_t           wait-state counter word
// ---------------------------------------------------------------------------
package dm_ctrl_pkg;

    localparam int unsigned WAIT_CW = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef logic [WAIT_CW-1:0] wait_cnt_t;

endpackage

// File: rtl/dm_wait_cnt.sv
// ---------------------------------------------------------------------------
// dm_wait_cnt
// Loadable wait-state down-counter. The counter stops at zero.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (count -> 0)
//   load      in   load load_val (takes priority over dec)
//   load_val  in   WAIT_CW-bit value to load
//   dec       in   decrement by one while non-zero
//   cnt       out  current count
//   zero      out  count equals zero
// ---------------------------------------------------------------------------
module dm_wait_cnt
    import dm_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  wait_cnt_t load_val,
    input  logic      dec,
    output wait_cnt_t cnt,
    output logic      zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl
// Data-memory access controller feeding the bus-connect mux. Accepts a read
// or write request in IDLE, drives a synchronous single-port SRAM for
// WAIT_CYC+1 ACCESS cycles while stalling the sequencer, and holds the last
// read word on dm_bc_dt. All outputs are registered.
// Optional feature (macro DM_RAW_FWD_EN): a 1-entry write-forwarding register
// that lets a read of the last written address complete without touching
// the SRAM.
// Parameters: DATA_W (data width), ADDR_W (address width),
//             WAIT_CYC (extra wait states, 0..15)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ps_dm_rd_en     read request (sampled in IDLE)
//   ps_dm_wr_en     write request (sampled in IDLE)
//   dg_dm_addr      access address
//   bc_dm_wdt       write data
//   mem_rdt         SRAM read data
//   mem_ce/mem_we   SRAM chip/write enable
//   mem_addr        SRAM address
//   mem_wdt         SRAM write data
//   dm_bc_dt        last completed read word
//   dm_rd_vld       pulse: dm_bc_dt updated
//   dm_ps_stall     sequencer hold, high in every ACCESS cycle
//   dm_ps_err       pulse: read and write requested together
// ---------------------------------------------------------------------------
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps_dm_rd_en,
    input  logic              ps_dm_wr_en,
    input  logic [ADDR_W-1:0] dg_dm_addr,
    input  logic [DATA_W-1:0] bc_dm_wdt,
    input  logic [DATA_W-1:0] mem_rdt,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdt,
    output logic [DATA_W-1:0] dm_bc_dt,
    output logic              dm_rd_vld,
    output logic              dm_ps_stall,
    output logic              dm_ps_err
);

    if (WAIT_CYC > 15) begin : g_wait_cyc_range
        $error("dm_access_ctrl: WAIT_CYC must be in 0..15");
    end

    logic [0:0]  state;
    logic        op_q;
    logic        accept;
    logic        fwd_hit;
    logic        start;
    logic        cnt_zero;
    wait_cnt_t   cnt;
    logic [DATA_W-1:0] fwd_data;

    assign accept = (state == ST_IDLE) && (ps_dm_rd_en || ps_dm_wr_en);
    assign start  = accept && !fwd_hit;

    dm_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (WAIT_CW'(WAIT_CYC)),
        .dec      (state == ST_ACCESS),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

`ifdef DM_RAW_FWD_EN
    logic              fwd_vld;
    logic [ADDR_W-1:0] fwd_addr;

    // A combined rd/wr request is a write, so it never forwards.
    assign fwd_hit = ps_dm_rd_en && !ps_dm_wr_en && fwd_vld
                     && (dg_dm_addr == fwd_addr);

    // mem_addr/mem_wdt still hold the latched request on the final edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else if ((state == ST_ACCESS) && cnt_zero && (op_q == OP_WR)) begin
            fwd_vld  <= 1'b1;
            fwd_addr <= mem_addr;
            fwd_data <= mem_wdt;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_RD;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdt     <= '0;
            dm_bc_dt    <= '0;
            dm_rd_vld   <= 1'b0;
            dm_ps_stall <= 1'b0;
            dm_ps_err   <= 1'b0;
        end else begin
            dm_rd_vld <= 1'b0;
            dm_ps_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dm_ps_err <= ps_dm_rd_en && ps_dm_wr_en;
                        if (fwd_hit) begin
                            dm_bc_dt  <= fwd_data;
                            dm_rd_vld <= 1'b1;
                        end else begin
                            // mem_addr/mem_wdt double as the request latch.
                            state       <= ST_ACCESS;
                            op_q        <= ps_dm_wr_en ? OP_WR : OP_RD;
                            mem_ce      <= 1'b1;
                            mem_we      <= ps_dm_wr_en;
                            mem_addr    <= dg_dm_addr;
                            mem_wdt     <= bc_dm_wdt;
                            dm_ps_stall <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state       <= ST_IDLE;
                        mem_ce      <= 1'b0;
                        mem_we      <= 1'b0;
                        dm_ps_stall <= 1'b0;
                        if (op_q == OP_RD) begin
                            dm_bc_dt  <= mem_rdt;
                            dm_rd_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_access_ctrl
// Three controller instances share one clock and reset:
//   index 0: WAIT_CYC=1, index 1: WAIT_CYC=0, index 2: WAIT_CYC=3
// Each has its own SRAM model (synchronous write, combinational read).
// Flag vector per instance: {mem_ce, mem_we, dm_ps_stall, dm_rd_vld, dm_ps_err}
// ---------------------------------------------------------------------------
module tb_dm_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        rd_en  [3];
    logic        wr_en  [3];
    logic [15:0] addr   [3];
    logic [15:0] wdt    [3];
    logic [15:0] rdt    [3];
    logic        ce     [3];
    logic        we     [3];
    logic [15:0] maddr  [3];
    logic [15:0] mwdt   [3];
    logic [15:0] bc_dt  [3];
    logic        vld    [3];
    logic        stall  [3];
    logic        err    [3];

    logic [15:0] mem [3][256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_access_ctrl #(
            .DATA_W   (16),
            .ADDR_W   (16),
            .WAIT_CYC ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .ps_dm_rd_en (rd_en[g]),
            .ps_dm_wr_en (wr_en[g]),
            .dg_dm_addr  (addr[g]),
            .bc_dm_wdt   (wdt[g]),
            .mem_rdt     (rdt[g]),
            .mem_ce      (ce[g]),
            .mem_we      (we[g]),
            .mem_addr    (maddr[g]),
            .mem_wdt     (mwdt[g]),
            .dm_bc_dt    (bc_dt[g]),
            .dm_rd_vld   (vld[g]),
            .dm_ps_stall (stall[g]),
            .dm_ps_err   (err[g])
        );
        assign rdt[g] = mem[g][maddr[g][7:0]];
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ce[g] && we[g]) mem[g][maddr[g][7:0]] <= mwdt[g];
        end
    end

    function automatic logic [4:0] flags(input int i);
        return {ce[i], we[i], stall[i], vld[i], err[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        rd_en[i] = r;
        wr_en[i] = w;
        addr[i]  = a;
        wdt[i]   = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) req(i, 1'b1, 1'b0, 16'h0010, 16'h1111);
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({flags(i), bc_dt[i], maddr[i], mwdt[i]} !== 53'd0) begin
                    bad++;
                    $display("FAIL reset_outputs dut%0d cyc%0d got flags=%b dt=%h addr=%h wdt=%h exp all 0",
                             i, c, flags(i), bc_dt[i], maddr[i], mwdt[i]);
                end
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) req(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_write_read();
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        tick();
        total++;
        if ({flags(0), maddr[0], mwdt[0]} !== {5'b11100, 16'h0010, 16'hBEEF}) begin
            bad++;
            $display("FAIL wr_c1 got %b %h %h exp 11100 0010 beef", flags(0), maddr[0], mwdt[0]);
        end
        // Inputs change mid-access; the latched request must be unaffected.
        req(0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        tick();
        total++;
        if ({flags(0), maddr[0], mwdt[0]} !== {5'b11100, 16'h0010, 16'hBEEF}) begin
            bad++;
            $display("FAIL wr_c2 got %b %h %h exp 11100 0010 beef", flags(0), maddr[0], mwdt[0]);
        end
        tick();
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00000, 16'h0000}) begin
            bad++;
            $display("FAIL wr_done got %b %h exp 00000 0000", flags(0), bc_dt[0]);
        end
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
`ifdef DM_RAW_FWD_EN
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00010, 16'hBEEF}) begin
            bad++;
            $display("FAIL rd_fwd got %b %h exp 00010 beef", flags(0), bc_dt[0]);
        end
        tick();
`else
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(0), maddr[0]} !== {5'b10100, 16'h0010}) begin
            bad++;
            $display("FAIL rd_c1 got %b %h exp 10100 0010", flags(0), maddr[0]);
        end
        tick();
        total++;
        if (flags(0) !== 5'b10100) begin
            bad++;
            $display("FAIL rd_c2 got %b exp 10100", flags(0));
        end
        tick();
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00010, 16'hBEEF}) begin
            bad++;
            $display("FAIL rd_done got %b %h exp 00010 beef", flags(0), bc_dt[0]);
        end
        tick();
`endif
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00000, 16'hBEEF}) begin
            bad++;
            $display("FAIL rd_after got %b %h exp 00000 beef", flags(0), bc_dt[0]);
        end
    endtask

    task automatic test_read_hold();
        req(1, 1'b0, 1'b1, 16'h0004, 16'h1234);
        tick();
        total++;
        if (flags(1) !== 5'b11100) begin
            bad++;
            $display("FAIL w0_wr got %b exp 11100", flags(1));
        end
        req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        // Second write elsewhere so a forwarding build still reads from memory.
        req(1, 1'b0, 1'b1, 16'h0100, 16'h0000);
        tick();
        req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        req(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        tick();
        req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(1), maddr[1]} !== {5'b10100, 16'h0004}) begin
            bad++;
            $display("FAIL w0_rd_c1 got %b %h exp 10100 0004", flags(1), maddr[1]);
        end
        tick();
        total++;
        if ({flags(1), bc_dt[1]} !== {5'b00010, 16'h1234}) begin
            bad++;
            $display("FAIL w0_rd_done got %b %h exp 00010 1234", flags(1), bc_dt[1]);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({flags(1), bc_dt[1]} !== {5'b00000, 16'h1234}) begin
                bad++;
                $display("FAIL w0_hold cyc%0d got %b %h exp 00000 1234", c, flags(1), bc_dt[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_f [4];
        exp_f = '{5'b10100, 5'b00010, 5'b10100, 5'b00010};
        req(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (flags(1) !== exp_f[c]) begin
                bad++;
                $display("FAIL b2b cyc%0d got %b exp %b", c, flags(1), exp_f[c]);
            end
        end
        req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        total++;
        if ({flags(1), bc_dt[1]} !== {5'b00000, 16'h1234}) begin
            bad++;
            $display("FAIL b2b_end got %b %h exp 00000 1234", flags(1), bc_dt[1]);
        end
    endtask

    task automatic test_err();
        req(0, 1'b1, 1'b1, 16'h0020, 16'h00AA);
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(0), maddr[0], mwdt[0]} !== {5'b11101, 16'h0020, 16'h00AA}) begin
            bad++;
            $display("FAIL err_c1 got %b %h %h exp 11101 0020 00aa", flags(0), maddr[0], mwdt[0]);
        end
        tick();
        total++;
        if (flags(0) !== 5'b11100) begin
            bad++;
            $display("FAIL err_c2 got %b exp 11100", flags(0));
        end
        tick();
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00000, 16'hBEEF}) begin
            bad++;
            $display("FAIL err_done got %b %h exp 00000 beef", flags(0), bc_dt[0]);
        end
        total++;
        if (mem[0][8'h20] !== 16'h00AA) begin
            bad++;
            $display("FAIL err_memword got %h exp 00aa", mem[0][8'h20]);
        end
    endtask

    task automatic test_reset_abort();
        req(2, 1'b0, 1'b1, 16'h0008, 16'h7777);
        tick();
        req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (flags(2) !== 5'b11100) begin
            bad++;
            $display("FAIL w3_wr_last got %b exp 11100", flags(2));
        end
        tick();
        total++;
        if (flags(2) !== 5'b00000) begin
            bad++;
            $display("FAIL w3_wr_done got %b exp 00000", flags(2));
        end
        req(2, 1'b1, 1'b0, 16'h0009, 16'h0000);
        tick();
        req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        total++;
        if ({flags(2), maddr[2]} !== {5'b10100, 16'h0009}) begin
            bad++;
            $display("FAIL abort_pre got %b %h exp 10100 0009", flags(2), maddr[2]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({flags(2), bc_dt[2], maddr[2]} !== 37'd0) begin
            bad++;
            $display("FAIL abort_rst got %b %h %h exp 00000 0000 0000", flags(2), bc_dt[2], maddr[2]);
        end
        total++;
        if (bc_dt[0] !== 16'h0000) begin
            bad++;
            $display("FAIL abort_rst_dt0 got %h exp 0000", bc_dt[0]);
        end
        tick();
        total++;
        if (flags(2) !== 5'b00000) begin
            bad++;
            $display("FAIL abort_idle got %b exp 00000", flags(2));
        end
        req(2, 1'b1, 1'b0, 16'h0008, 16'h0000);
        tick();
        req(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(2), maddr[2]} !== {5'b10100, 16'h0008}) begin
            bad++;
            $display("FAIL w3_rd_c1 got %b %h exp 10100 0008", flags(2), maddr[2]);
        end
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (flags(2) !== 5'b10100) begin
            bad++;
            $display("FAIL w3_rd_c4 got %b exp 10100", flags(2));
        end
        tick();
        total++;
        if ({flags(2), bc_dt[2]} !== {5'b00010, 16'h7777}) begin
            bad++;
            $display("FAIL w3_rd_done got %b %h exp 00010 7777", flags(2), bc_dt[2]);
        end
    endtask

    task automatic test_forward();
        req(0, 1'b0, 1'b1, 16'h0030, 16'h5A5A);
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        total++;
        if (flags(0) !== 5'b00000) begin
            bad++;
            $display("FAIL fw_wr_done got %b exp 00000", flags(0));
        end
        req(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
`ifdef DM_RAW_FWD_EN
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00010, 16'h5A5A}) begin
            bad++;
            $display("FAIL fw_hit got %b %h exp 00010 5a5a", flags(0), bc_dt[0]);
        end
        tick();
        req(0, 1'b1, 1'b0, 16'h0031, 16'h0000);
        tick();
        req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        total++;
        if ({flags(0), maddr[0]} !== {5'b10100, 16'h0031}) begin
            bad++;
            $display("FAIL fw_miss got %b %h exp 10100 0031", flags(0), maddr[0]);
        end
        tick();
        tick();
        total++;
        if (flags(0) !== 5'b00010) begin
            bad++;
            $display("FAIL fw_miss_done got %b exp 00010", flags(0));
        end
`else
        total++;
        if ({flags(0), maddr[0]} !== {5'b10100, 16'h0030}) begin
            bad++;
            $display("FAIL nofw_rd_c1 got %b %h exp 10100 0030", flags(0), maddr[0]);
        end
        tick();
        tick();
        total++;
        if ({flags(0), bc_dt[0]} !== {5'b00010, 16'h5A5A}) begin
            bad++;
            $display("FAIL nofw_rd_done got %b %h exp 00010 5a5a", flags(0), bc_dt[0]);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_hold();
        test_back_to_back();
        test_err();
        test_reset_abort();
        test_forward();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
